branch_predict_unit: RTL and testbench
======================================

# branch_predict_unit

Parametrised branch resolution and prediction unit for the pipelined MIPS core. It replaces the bare combinational comparator with three parts: a signed condition comparator, a bimodal table of 2-bit saturating counters looked up by the IF stage, and registered resolve outputs that give the hazard/flush logic a one-cycle mispredict pulse. It also keeps saturating branch and mispredict statistics counters for the testbench and for debug.

## Interface
- WIDTH, 32, operand width of res_a/res_b (signed two's complement)
- IDX_BITS, 6, predictor index width; table depth = 2^IDX_BITS entries
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- if_pc  input  32  IF-stage PC used for lookup
- pred_taken  output  1  combinational prediction for if_pc
- res_valid  input  1  a branch is resolving this cycle
- res_stall  input  1  pipeline stall; masks res_valid
- res_pc  input  32  PC of the resolving branch
- res_a, res_b  input  WIDTH  compare operands (forwarded values)
- res_op  input  3  condition code
- res_pred  input  1  prediction carried down the pipe with the branch
- br  output  1  registered resolved direction
- mispredict  output  1  registered one-cycle pulse, resolved direction != res_pred
- br_count  output  32  number of accepted resolutions, saturating
- miss_count  output  32  number of mispredicts, saturating

## Operation
- Index: idx(pc) = pc[IDX_BITS+1:2]. Word-aligned. There are no tags, so aliasing PCs share an entry.
- Condition codes, with signed compare on res_a and with res_b used only by ops 0 and 1:
  - 0: res_a == res_b
  - 1: res_a != res_b
  - 2: res_a < 0
  - 3: res_a <= 0
  - 4: res_a > 0
  - 5: res_a >= 0
  - 6: always taken
  - 7: never taken (reserved)
- Accept = res_valid & ~res_stall. All state changes are gated by accept.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Prediction = counter[1].
- Training on accept, for ops 0–5 only:
  - Taken: counter increments and saturates at 11.
  - Not taken: counter decrements and saturates at 00.
  - Ops 6 and 7 never modify the table.
- Resolve outputs, registered at the edge that ends the accept cycle:
  - br = taken.
  - mispredict = (taken != res_pred). This applies to every op, including 6 and 7.
- Non-accept cycle (res_valid low, or stalled):
  - mispredict is cleared to 0.
  - br holds its value.
- Statistics:
  - br_count increments on every accept.
  - miss_count increments on every accept with a mispredict.
  - Both saturate at 0xFFFFFFFF and do not wrap.
- Lookup is a pure combinational read of the table. When the lookup and update indices match in the same cycle, pred_taken returns the pre-update value. There is no bypass.

## Timing
- Reset, asynchronous and taking effect immediately:
  - All table entries = 01.
  - br = 0, mispredict = 0, br_count = 0, miss_count = 0.
  - pred_taken therefore reads 0 for every PC.
- Reset asserted mid-operation discards the in-flight resolution: no counter is updated. The first accept after reset deasserts is processed normally.
- Latency:
  - pred_taken: 0 cycles from if_pc.
  - br and mispredict: 1 cycle after the accept cycle.
  - Table update: visible to lookup starting the cycle after accept.
- mispredict is high for exactly one cycle per mispredicted accept. Back-to-back accepts give back-to-back independent pulses.
- No internal stall or backpressure. The unit accepts one resolution every cycle.
- Width rules:
  - Compare is performed at WIDTH bits, signed.
  - PC bits above IDX_BITS+1 and PC bits [1:0] are ignored.

## Test plan
- Reset then lookup: assert reset with if_pc swept over 0x3000..0x30FC → pred_taken = 0 everywhere; br, mispredict and both counters = 0.
- Training and saturation: three accepts at res_pc = 0x3000, op 0, A = B = 5, res_pred = 0 → pred_taken at 0x3000 goes 0 → 1 → 1. Entry reaches 11 and stays there. mispredict pulses 3 times, br_count = 3, miss_count = 3.
- Signed compare: op 2 with A = 0x80000000 → br = 1. Op 4 with A = 0x80000000 → br = 0. Op 3 with A = 0 → br = 1. Op 1 with A = B = 7 → br = 0. Op 6 → br = 1, table unchanged. Op 7 → br = 0, table unchanged.
- Aliasing and same-cycle bypass (IDX_BITS = 6):
  - Train 0x3000 to 11.
  - Resolve op 0 not-taken at 0x3100 while if_pc = 0x3000 in the same cycle → pred_taken = 1 that cycle, still 1 the next cycle (entry now 10).
  - One more not-taken at 0x3100 → pred_taken = 0.
- Stall masking: res_valid = 1 with res_stall = 1 and a would-be mispredict → no mispredict pulse, br unchanged, counters unchanged, table unchanged.
- Reset mid-operation and counter saturation:
  - Assert reset in the same cycle as an accept → all state returns to its reset values.
  - Preload br_count and miss_count to 0xFFFFFFFE via force, apply 2 mispredicted accepts → both read 0xFFFFFFFF.

Source files
------------

// File: rtl/branch_predict_unit_if.sv
// branch_predict_unit_if: predictor bus; master (pipeline) drives if_pc/res_*, slave (unit) returns pred_taken, br, mispredict, br_count, miss_count
interface branch_predict_unit_if #(
  parameter int WIDTH = 32
);
  logic [31:0] if_pc;
  logic pred_taken;
  logic res_valid;
  logic res_stall;
  logic [31:0] res_pc;
  logic [WIDTH-1:0] res_a;
  logic [WIDTH-1:0] res_b;
  logic [2:0] res_op;
  logic res_pred;
  logic br;
  logic mispredict;
  logic [31:0] br_count;
  logic [31:0] miss_count;
  modport master (
    output if_pc, res_valid, res_stall, res_pc, res_a, res_b, res_op, res_pred,
    input pred_taken, br, mispredict, br_count, miss_count
  );
  modport slave (
    input if_pc, res_valid, res_stall, res_pc, res_a, res_b, res_op, res_pred,
    output pred_taken, br, mispredict, br_count, miss_count
  );
endinterface

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: bimodal 2-bit predictor + signed branch comparator; ports clk, reset (async high), bus (slave: lookup, resolve, br/mispredict, saturating stats)
module branch_predict_unit #(
  parameter int WIDTH = 32,
  parameter int IDX_BITS = 6
) (
  input logic clk,
  input logic reset,
  branch_predict_unit_if.slave bus
);
  localparam int DEPTH = 1 << IDX_BITS;
  logic [1:0] tbl [DEPTH];
  logic [IDX_BITS-1:0] lidx, ridx;
  logic signed [WIDTH-1:0] a, b;
  logic accept, taken, train, br_q, miss_q, miss;
  logic [1:0] cnt, cnt_nxt;
  logic [31:0] br_cnt, miss_cnt;
  assign lidx = bus.if_pc[IDX_BITS+1:2];
  assign ridx = bus.res_pc[IDX_BITS+1:2];
  assign a = bus.res_a;
  assign b = bus.res_b;
  assign accept = bus.res_valid & ~bus.res_stall;
  assign train = accept & (bus.res_op < 3'd6);
  assign miss = taken != bus.res_pred;
  assign cnt = tbl[ridx];
  assign cnt_nxt = taken ? (cnt == 2'b11 ? cnt : cnt + 2'd1) : (cnt == 2'b00 ? cnt : cnt - 2'd1);
  assign bus.pred_taken = tbl[lidx][1];
  assign bus.br = br_q;
  assign bus.mispredict = miss_q;
  assign bus.br_count = br_cnt;
  assign bus.miss_count = miss_cnt;
  always_comb begin
    taken = 1'b0;
    case (bus.res_op)
      3'd0: taken = a == b;
      3'd1: taken = a != b;
      3'd2: taken = a < 0;
      3'd3: taken = a <= 0;
      3'd4: taken = a > 0;
      3'd5: taken = a >= 0;
      3'd6: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= 2'b01;
      br_q <= 1'b0;
      miss_q <= 1'b0;
      br_cnt <= '0;
      miss_cnt <= '0;
    end else begin
      miss_q <= accept & miss;
      if (accept) begin
        br_q <= taken;
        br_cnt <= br_cnt + {31'd0, ~&br_cnt};
        miss_cnt <= miss_cnt + {31'd0, miss & ~&miss_cnt};
      end
      if (train) tbl[ridx] <= cnt_nxt;
    end
  end
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed self-checking bench for branch_predict_unit
module tb_branch_predict_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int errors = 0;
  int checks = 0;
  branch_predict_unit_if #(.WIDTH(32)) bus ();
  branch_predict_unit #(.WIDTH(32), .IDX_BITS(6)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic s, input logic [31:0] pc, input logic [2:0] op, input logic [31:0] ra, input logic [31:0] rb, input logic p);
    bus.res_valid = v;
    bus.res_stall = s;
    bus.res_pc = pc;
    bus.res_op = op;
    bus.res_a = ra;
    bus.res_b = rb;
    bus.res_pred = p;
  endtask
  task automatic test_reset();
    drive(1'b0, 1'b0, 32'h0, 3'd0, 32'h0, 32'h0, 1'b0);
    bus.if_pc = 32'h3000;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 64; i++) begin
      bus.if_pc = 32'h3000 + 32'(i * 4);
      #1;
      checks++; if (bus.pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred pc=%h got=%b exp=0", bus.if_pc, bus.pred_taken); end
    end
    checks++; if (bus.br !== 1'b0) begin errors++; $display("FAIL reset_br got=%b exp=0", bus.br); end
    checks++; if (bus.mispredict !== 1'b0) begin errors++; $display("FAIL reset_miss got=%b exp=0", bus.mispredict); end
    checks++; if (bus.br_count !== 32'd0) begin errors++; $display("FAIL reset_brcnt got=%h exp=0", bus.br_count); end
    checks++; if (bus.miss_count !== 32'd0) begin errors++; $display("FAIL reset_misscnt got=%h exp=0", bus.miss_count); end
    step();
    reset = 1'b0;
    step();
  endtask
  task automatic test_training();
    bus.if_pc = 32'h3000;
    drive(1'b1, 1'b0, 32'h3000, 3'd0, 32'd5, 32'd5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.pred_taken !== 1'b1) begin errors++; $display("FAIL train_pred%0d got=%b exp=1", i, bus.pred_taken); end
      checks++; if (bus.mispredict !== 1'b1) begin errors++; $display("FAIL train_miss%0d got=%b exp=1", i, bus.mispredict); end
      checks++; if (bus.br !== 1'b1) begin errors++; $display("FAIL train_br%0d got=%b exp=1", i, bus.br); end
    end
    bus.res_valid = 1'b0;
    step();
    checks++; if (bus.mispredict !== 1'b0) begin errors++; $display("FAIL train_miss_clear got=%b exp=0", bus.mispredict); end
    checks++; if (bus.br !== 1'b1) begin errors++; $display("FAIL train_br_hold got=%b exp=1", bus.br); end
    checks++; if (bus.br_count !== 32'd3) begin errors++; $display("FAIL train_brcnt got=%0d exp=3", bus.br_count); end
    checks++; if (bus.miss_count !== 32'd3) begin errors++; $display("FAIL train_misscnt got=%0d exp=3", bus.miss_count); end
  endtask
  task automatic test_signed();
    logic [2:0] ops [5] = '{3'd2, 3'd4, 3'd3, 3'd1, 3'd5};
    logic [31:0] as [5] = '{32'h80000000, 32'h80000000, 32'h0, 32'd7, 32'hFFFFFFFF};
    logic preds [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic exps [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 32'h3004, ops[i], as[i], 32'd7, preds[i]);
      step();
      checks++; if (bus.br !== exps[i]) begin errors++; $display("FAIL signed_op%0d_br got=%b exp=%b", ops[i], bus.br, exps[i]); end
      checks++; if (bus.mispredict !== 1'b0) begin errors++; $display("FAIL signed_op%0d_miss got=%b exp=0", ops[i], bus.mispredict); end
    end
    bus.if_pc = 32'h3008;
    drive(1'b1, 1'b0, 32'h3008, 3'd6, 32'd0, 32'd1, 1'b0);
    step();
    checks++; if (bus.br !== 1'b1) begin errors++; $display("FAIL op6_br got=%b exp=1", bus.br); end
    checks++; if (bus.mispredict !== 1'b1) begin errors++; $display("FAIL op6_miss got=%b exp=1", bus.mispredict); end
    checks++; if (bus.pred_taken !== 1'b0) begin errors++; $display("FAIL op6_table got=%b exp=0", bus.pred_taken); end
    drive(1'b1, 1'b0, 32'h3008, 3'd7, 32'd0, 32'd0, 1'b1);
    step();
    checks++; if (bus.br !== 1'b0) begin errors++; $display("FAIL op7_br got=%b exp=0", bus.br); end
    checks++; if (bus.mispredict !== 1'b1) begin errors++; $display("FAIL op7_miss got=%b exp=1", bus.mispredict); end
    drive(1'b1, 1'b0, 32'h3008, 3'd0, 32'd9, 32'd9, 1'b0);
    step();
    checks++; if (bus.pred_taken !== 1'b1) begin errors++; $display("FAIL op7_table got=%b exp=1", bus.pred_taken); end
    bus.res_valid = 1'b0;
    step();
  endtask
  task automatic test_alias();
    bus.if_pc = 32'h3000;
    drive(1'b1, 1'b0, 32'h3100, 3'd0, 32'd1, 32'd2, 1'b1);
    #1;
    checks++; if (bus.pred_taken !== 1'b1) begin errors++; $display("FAIL alias_same_cycle1 got=%b exp=1", bus.pred_taken); end
    step();
    checks++; if (bus.pred_taken !== 1'b1) begin errors++; $display("FAIL alias_after1 got=%b exp=1", bus.pred_taken); end
    checks++; if (bus.br !== 1'b0) begin errors++; $display("FAIL alias_br got=%b exp=0", bus.br); end
    checks++; if (bus.mispredict !== 1'b1) begin errors++; $display("FAIL alias_miss got=%b exp=1", bus.mispredict); end
    checks++; if (bus.pred_taken !== 1'b1) begin errors++; $display("FAIL alias_same_cycle2 got=%b exp=1", bus.pred_taken); end
    step();
    checks++; if (bus.pred_taken !== 1'b0) begin errors++; $display("FAIL alias_after2 got=%b exp=0", bus.pred_taken); end
    bus.res_valid = 1'b0;
    step();
    checks++; if (bus.br_count !== 32'd13) begin errors++; $display("FAIL alias_brcnt got=%0d exp=13", bus.br_count); end
    checks++; if (bus.miss_count !== 32'd8) begin errors++; $display("FAIL alias_misscnt got=%0d exp=8", bus.miss_count); end
  endtask
  task automatic test_stall();
    bus.if_pc = 32'h3000;
    drive(1'b1, 1'b1, 32'h3000, 3'd0, 32'd4, 32'd4, 1'b0);
    step();
    checks++; if (bus.mispredict !== 1'b0) begin errors++; $display("FAIL stall_miss got=%b exp=0", bus.mispredict); end
    checks++; if (bus.br !== 1'b0) begin errors++; $display("FAIL stall_br got=%b exp=0", bus.br); end
    checks++; if (bus.br_count !== 32'd13) begin errors++; $display("FAIL stall_brcnt got=%0d exp=13", bus.br_count); end
    checks++; if (bus.miss_count !== 32'd8) begin errors++; $display("FAIL stall_misscnt got=%0d exp=8", bus.miss_count); end
    checks++; if (bus.pred_taken !== 1'b0) begin errors++; $display("FAIL stall_table got=%b exp=0", bus.pred_taken); end
    drive(1'b0, 1'b0, 32'h3000, 3'd0, 32'd0, 32'd0, 1'b0);
    step();
  endtask
  task automatic test_reset_mid();
    bus.if_pc = 32'h3008;
    drive(1'b1, 1'b0, 32'h3008, 3'd0, 32'd3, 32'd3, 1'b0);
    reset = 1'b1;
    step();
    checks++; if (bus.br !== 1'b0) begin errors++; $display("FAIL rmid_br got=%b exp=0", bus.br); end
    checks++; if (bus.mispredict !== 1'b0) begin errors++; $display("FAIL rmid_miss got=%b exp=0", bus.mispredict); end
    checks++; if (bus.br_count !== 32'd0) begin errors++; $display("FAIL rmid_brcnt got=%0d exp=0", bus.br_count); end
    checks++; if (bus.miss_count !== 32'd0) begin errors++; $display("FAIL rmid_misscnt got=%0d exp=0", bus.miss_count); end
    checks++; if (bus.pred_taken !== 1'b0) begin errors++; $display("FAIL rmid_table got=%b exp=0", bus.pred_taken); end
    reset = 1'b0;
    step();
    checks++; if (bus.pred_taken !== 1'b1) begin errors++; $display("FAIL rmid_first_accept_pred got=%b exp=1", bus.pred_taken); end
    checks++; if (bus.br_count !== 32'd1) begin errors++; $display("FAIL rmid_first_accept_cnt got=%0d exp=1", bus.br_count); end
    checks++; if (bus.mispredict !== 1'b1) begin errors++; $display("FAIL rmid_first_accept_miss got=%b exp=1", bus.mispredict); end
    bus.res_valid = 1'b0;
    step();
  endtask
  task automatic test_saturation();
    force dut.br_cnt = 32'hFFFFFFFE;
    force dut.miss_cnt = 32'hFFFFFFFE;
    #1;
    release dut.br_cnt;
    release dut.miss_cnt;
    drive(1'b1, 1'b0, 32'h3010, 3'd6, 32'd0, 32'd0, 1'b0);
    step();
    checks++; if (bus.br_count !== 32'hFFFFFFFF) begin errors++; $display("FAIL sat1_brcnt got=%h exp=ffffffff", bus.br_count); end
    checks++; if (bus.miss_count !== 32'hFFFFFFFF) begin errors++; $display("FAIL sat1_misscnt got=%h exp=ffffffff", bus.miss_count); end
    step();
    checks++; if (bus.br_count !== 32'hFFFFFFFF) begin errors++; $display("FAIL sat2_brcnt got=%h exp=ffffffff", bus.br_count); end
    checks++; if (bus.miss_count !== 32'hFFFFFFFF) begin errors++; $display("FAIL sat2_misscnt got=%h exp=ffffffff", bus.miss_count); end
    checks++; if (bus.mispredict !== 1'b1) begin errors++; $display("FAIL sat_back_to_back_miss got=%b exp=1", bus.mispredict); end
    bus.res_valid = 1'b0;
    step();
  endtask
  initial begin
    test_reset();
    test_training();
    test_signed();
    test_alias();
    test_stall();
    test_reset_mid();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
